// File: rtl/gpio_serial_loader_pkg.sv
// Shared definitions for the GPIO pad-configuration serial loader.
// Holds the per-pad word layout, the sequencer state encodings and a state-class helper.
package gpio_serial_loader_pkg;

  localparam int PAD_CTRL_BITS = 10;

  localparam int MGMT_EN  = 0;
  localparam int OE_OVR   = 1;
  localparam int IE       = 2;
  localparam int OE       = 3;
  localparam int SCHMITT  = 4;
  localparam int SLEW     = 5;
  localparam int PD       = 6;
  localparam int PU       = 7;
  localparam int DRIVE_LO = 8;
  localparam int DRIVE_HI = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_LO   = 3'd1,
    SHIFT_HI   = 3'd2,
    LOAD_SETUP = 3'd3,
    LOAD_HI    = 3'd4,
    FINISH     = 3'd5
  } loader_state_e;

  // States whose duration is measured by the phase timer
  function automatic logic timed_state(input loader_state_e s);
    case (s)
      SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD_HI: timed_state = 1'b1;
      default:                                 timed_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_serial_phase_tmr.sv
// Phase timer: counts CLK_DIV cycles per serial phase and flags the last cycle of each phase.
// Held at zero while clr is high so every timed state starts with a full phase.
module gpio_serial_phase_tmr #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic phase_end
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_r;

  assign phase_end = !clr && (cnt_r == LAST_CNT);

  // Phase cycle counter, restarting at every phase boundary
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr || phase_end) begin
      cnt_r <= {PW{1'b0}};
    end else begin
      cnt_r <= cnt_r + PW'(1);
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Sequencer that snapshots the per-pad config words, shifts them MSB-first down the
// gpio_control_block chain, then pulses serial_load so every block latches its word.
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_GPIO = 19,
  parameter int CLK_DIV  = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] cfg_words,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              serial_clock,
  output logic                              serial_load,
  output logic                              serial_resetn,
  output logic                              serial_data_out
);

  localparam int N_BITS = NUM_GPIO * PAD_CTRL_BITS;
  localparam int BW     = $clog2(N_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N_BITS - 1);

  loader_state_e     state_r;
  logic [N_BITS-1:0] shift_r;
  logic [BW-1:0]     bits_left_r;
  logic              phase_end_s;
  logic              phase_clr_s;

  assign phase_clr_s = !timed_state(state_r);

  gpio_serial_phase_tmr #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tmr (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (phase_clr_s),
    .phase_end (phase_end_s)
  );

  // Transfer sequencer; outputs are set on the edge that enters each state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r         <= IDLE;
      shift_r         <= {N_BITS{1'b0}};
      bits_left_r     <= {BW{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
      serial_clock    <= 1'b0;
      serial_load     <= 1'b0;
      serial_data_out <= 1'b0;
      serial_resetn   <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
      done          <= 1'b0;
      case (state_r)
        IDLE: begin
          // The first bit goes out directly; the rest of the snapshot waits pre-shifted
          if (start) begin
            shift_r         <= {cfg_words[N_BITS-2:0], 1'b0};
            serial_data_out <= cfg_words[N_BITS-1];
            bits_left_r     <= LAST_BIT;
            busy            <= 1'b1;
            state_r         <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end_s) begin
            serial_clock <= 1'b1;
            state_r      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end_s) begin
            serial_clock <= 1'b0;
            if (bits_left_r == {BW{1'b0}}) begin
              serial_data_out <= 1'b0;
              state_r         <= LOAD_SETUP;
            end else begin
              bits_left_r     <= bits_left_r - BW'(1);
              serial_data_out <= shift_r[N_BITS-1];
              shift_r         <= {shift_r[N_BITS-2:0], 1'b0};
              state_r         <= SHIFT_LO;
            end
          end
        end
        LOAD_SETUP: begin
          if (phase_end_s) begin
            serial_load <= 1'b1;
            state_r     <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (phase_end_s) begin
            serial_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= FINISH;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          busy            <= 1'b0;
          serial_clock    <= 1'b0;
          serial_load     <= 1'b0;
          serial_data_out <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: two loaders drive modelled gpio_control_block chains,
// and latched pad words are checked against a scoreboard of start-time snapshots.
module tb_gpio_serial_loader;
  import gpio_serial_loader_pkg::*;

  localparam int NA = 2;
  localparam int DA = 2;
  localparam int NB = 1;
  localparam int DB = 1;
  localparam int BA = NA * PAD_CTRL_BITS;
  localparam int BB = NB * PAD_CTRL_BITS;
  localparam int LAT_A = DA * (2 * BA + 2) + 1;
  localparam int LAT_B = DB * (2 * BB + 2) + 1;
  localparam int BUDGET = 400;
  localparam logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULT =
    PAD_CTRL_BITS'((1 << MGMT_EN) | (1 << IE) | (1 << PD));

  logic clk = 1'b0;
  logic resetn;

  logic [BA-1:0] a_cfg;
  logic a_start, a_busy, a_done, a_sclk, a_sload, a_sresetn, a_sdo;
  logic [BB-1:0] b_cfg;
  logic b_start, b_busy, b_done, b_sclk, b_sload, b_sresetn, b_sdo;

  int vectors = 0;
  int miscompares = 0;

  logic [BA-1:0] exp_a[$];
  logic [BB-1:0] exp_b[$];

  // Chain models and event counters
  logic [BA-1:0] a_chain, a_pads;
  logic [BB-1:0] b_chain, b_pads;
  logic a_psclk = 1'b0, a_pload = 1'b0, b_psclk = 1'b0, b_pload = 1'b0;
  int a_rise = 0, a_done_cnt = 0, a_both = 0;
  int b_rise = 0, b_done_cnt = 0, b_both = 0, b_dhi = 0;

  always #5 clk = ~clk;

  gpio_serial_loader #(.NUM_GPIO(NA), .CLK_DIV(DA)) u_dut_a (
    .clk(clk), .resetn(resetn), .cfg_words(a_cfg), .start(a_start),
    .busy(a_busy), .done(a_done), .serial_clock(a_sclk), .serial_load(a_sload),
    .serial_resetn(a_sresetn), .serial_data_out(a_sdo)
  );

  gpio_serial_loader #(.NUM_GPIO(NB), .CLK_DIV(DB)) u_dut_b (
    .clk(clk), .resetn(resetn), .cfg_words(b_cfg), .start(b_start),
    .busy(b_busy), .done(b_done), .serial_clock(b_sclk), .serial_load(b_sload),
    .serial_resetn(b_sresetn), .serial_data_out(b_sdo)
  );

  // Chain A: LSB-in shift on serial_clock rise, latch on serial_load rise
  always @(negedge clk) begin
    if (!a_sresetn) begin
      a_chain <= {NA{GPIO_DEFAULT}};
      a_pads  <= {NA{GPIO_DEFAULT}};
    end else begin
      if (a_sclk && !a_psclk) a_chain <= {a_chain[BA-2:0], a_sdo};
      if (a_sload && !a_pload) a_pads <= a_chain;
    end
    if (a_sclk && !a_psclk) a_rise <= a_rise + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (a_sclk && a_sload) a_both <= a_both + 1;
    a_psclk <= a_sclk;
    a_pload <= a_sload;
  end

  // Chain B: same model for the single-block chain
  always @(negedge clk) begin
    if (!b_sresetn) begin
      b_chain <= {NB{GPIO_DEFAULT}};
      b_pads  <= {NB{GPIO_DEFAULT}};
    end else begin
      if (b_sclk && !b_psclk) b_chain <= {b_chain[BB-2:0], b_sdo};
      if (b_sload && !b_pload) b_pads <= b_chain;
    end
    if (b_sclk && !b_psclk) b_rise <= b_rise + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_sclk && b_sload) b_both <= b_both + 1;
    if (b_sdo) b_dhi <= b_dhi + 1;
    b_psclk <= b_sclk;
    b_pload <= b_sload;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input bit push);
    @(negedge clk);
    a_start = 1'b1;
    if (push) exp_a.push_back(a_cfg);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic pulse_b(input bit push);
    @(negedge clk);
    b_start = 1'b1;
    if (push) exp_b.push_back(b_cfg);
    @(negedge clk);
    b_start = 1'b0;
  endtask

  // Wait for done on A (cyc0 = current cycle index after the start cycle), then score
  task automatic finish_a(input string tag, input int cyc0);
    int cyc;
    logic [BA-1:0] exp;
    cyc = cyc0;
    while (a_done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT_A);
    check({tag, "_busy_at_done"}, {31'd0, a_busy}, 32'd0);
    if (exp_a.size() > 0) exp = exp_a.pop_front();
    else exp = {BA{1'bx}};
    check({tag, "_pads"}, {12'd0, a_pads}, {12'd0, exp});
  endtask

  task automatic finish_b(input string tag, input int cyc0);
    int cyc;
    logic [BB-1:0] exp;
    cyc = cyc0;
    while (b_done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT_B);
    check({tag, "_busy_at_done"}, {31'd0, b_busy}, 32'd0);
    if (exp_b.size() > 0) exp = exp_b.pop_front();
    else exp = {BB{1'bx}};
    check({tag, "_pads"}, {22'd0, b_pads}, {22'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, h0;
    resetn  = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_cfg   = {BA{1'b0}};
    b_cfg   = {BB{1'b0}};
    repeat (3) @(negedge clk);
    check("reset_outs_a", {26'd0, a_busy, a_done, a_sclk, a_sload, a_sdo, a_sresetn}, 32'd0);
    check("reset_outs_b", {26'd0, b_busy, b_done, b_sclk, b_sload, b_sdo, b_sresetn}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("sresetn_release_a", {31'd0, a_sresetn}, 32'd1);
    check("sresetn_release_b", {31'd0, b_sresetn}, 32'd1);
    check("pads_default_a", {12'd0, a_pads}, {12'd0, {NA{GPIO_DEFAULT}}});

    // Two-block load with start pulses at +1 and +10 cycles into the transfer
    a_cfg = {10'h3C5, 10'h1A2};
    pulse_a(1'b1);
    check("t1_busy_cycle1", {31'd0, a_busy}, 32'd1);
    r0 = a_rise;
    d0 = a_done_cnt;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (8) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("t3_busy_after_starts", {31'd0, a_busy}, 32'd1);
    finish_a("t1", 11);
    check("t3_rises", a_rise - r0, BA);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("finish_start_ignored", {31'd0, a_busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("t3_done_pulses", a_done_cnt - d0, 32'd1);

    // Config changes mid-transfer must not reach the pads
    a_cfg = {10'h0F0, 10'h30F};
    pulse_a(1'b1);
    repeat (4) @(negedge clk);
    a_cfg = {BA{1'b1}};
    finish_a("t4_snap", 5);
    pulse_a(1'b1);
    finish_a("t4_ones", 1);

    // Abort with resetn at bit 7
    a_cfg = 20'h5A5A5;
    pulse_a(1'b0);
    d0 = a_done_cnt;
    repeat (28) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("t5_outs_after_reset", {28'd0, a_busy, a_sclk, a_sload, a_done}, 32'd0);
    check("t5_sresetn_low", {31'd0, a_sresetn}, 32'd0);
    @(negedge clk);
    check("t5_pads_default", {12'd0, a_pads}, {12'd0, {NA{GPIO_DEFAULT}}});
    repeat (100) @(negedge clk);
    check("t5_no_done", a_done_cnt - d0, 32'd0);
    check("t5_idle_busy", {31'd0, a_busy}, 32'd0);

    // Bit order on a single block at CLK_DIV=1
    b_cfg = 10'h200;
    h0 = b_dhi;
    r0 = b_rise;
    pulse_b(1'b1);
    finish_b("t2", 1);
    check("t2_data_high_cycles", b_dhi - h0, 2 * DB);
    check("t2_rises", b_rise - r0, BB);

    // Back-to-back transfers, second start on the cycle after done
    b_cfg = 10'h2D3;
    pulse_b(1'b1);
    finish_b("t6_first", 1);
    b_cfg = 10'h135;
    pulse_b(1'b1);
    finish_b("t6_second", 1);
    check("t6_clk_load_overlap_b", b_both, 32'd0);
    check("clk_load_overlap_a", a_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
